// File: rtl/cpu_0_mult_pkg.sv
// cpu_0_mult_pkg: shared constants and tag type for the multiply scheduler
package cpu_0_mult_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;
  localparam logic OP_LO = 1'b0;
  localparam logic OP_HI = 1'b1;
  localparam int HI_PASSES = 4;
  localparam logic [1:0] SH0  = 2'd0;
  localparam logic [1:0] SH16 = 2'd1;
  localparam logic [1:0] SH32 = 2'd2;
  typedef struct packed {
    logic       v;
    logic [1:0] sh;
  } tag_t;
endpackage

// File: rtl/cpu_0_mult_rr_arb.sv
// cpu_0_mult_rr_arb: one-hot round-robin arbiter, pointer moves past each winner
module cpu_0_mult_rr_arb #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);
  logic [PW-1:0] ptr;
  logic [PW-1:0] j;
  logic          found;
  always_comb begin
    idx   = '0;
    j     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = PW'((int'(ptr) + i) % NREQ);
      if (!found && valid[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    grant = (en && found) ? NREQ'(1) << idx : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (|grant) ptr <= PW'((int'(idx) + 1) % NREQ);
endmodule

// File: rtl/cpu_0_mult_sched.sv
// cpu_0_mult_sched: shares one external 32x32->32 multiply cell among NREQ requesters
// HI results are built from four 16x16 partial products accumulated into 64 bits.
module cpu_0_mult_sched
  import cpu_0_mult_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int CELL_LATENCY = 1,
  parameter int IDW          = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_src1,
  input  logic [32*NREQ-1:0] req_src2,
  input  logic [NREQ-1:0]   req_hi,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic [31:0]       A_mul_src1,
  output logic [31:0]       A_mul_src2,
  input  logic [31:0]       A_mul_cell_result
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [1:0]    st;
  logic [1:0]    pc;
  logic [31:0]   a, b;
  logic          hi;
  logic [PW-1:0] gidx;
  logic [63:0]   acc, acc_nxt;
  logic [31:0]   s1, s2;
  logic [1:0]    sh;
  logic          issue, last, drained;
  tag_t          tg [CELL_LATENCY+1];
  // Grant is masked by reset so req_ready reads 0 while reset is held.
  cpu_0_mult_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .clk(clk), .reset_n(reset_n), .en(st == S_IDLE && reset_n), .valid(req_valid),
    .grant(req_ready), .idx(gidx)
  );
  assign issue = st == S_ISSUE;
  assign last  = hi != OP_HI || pc == 2'(HI_PASSES - 1);
  always_comb begin
    s1      = hi ? {16'h0, pc[0] ? a[31:16] : a[15:0]} : a;
    s2      = hi ? {16'h0, pc[1] ? b[31:16] : b[15:0]} : b;
    sh      = (!hi || pc == 2'd0) ? SH0 : pc == 2'(HI_PASSES - 1) ? SH32 : SH16;
    acc_nxt = tg[CELL_LATENCY].v ? acc + ({32'h0, A_mul_cell_result} << {tg[CELL_LATENCY].sh, 4'h0}) : acc;
    drained = 1'b1;
    for (int i = 0; i < CELL_LATENCY; i++) if (tg[i].v) drained = 1'b0;
  end
  // tg[0] rides with the registered operands; tg[CELL_LATENCY] lines up with the cell result.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st         <= S_IDLE;
      pc         <= '0;
      a          <= '0;
      b          <= '0;
      hi         <= 1'b0;
      acc        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      A_mul_src1 <= '0;
      A_mul_src2 <= '0;
      for (int i = 0; i <= CELL_LATENCY; i++) tg[i] <= '0;
    end else begin
      tg[0] <= tag_t'{v: issue, sh: sh};
      for (int i = 1; i <= CELL_LATENCY; i++) tg[i] <= tg[i-1];
      A_mul_src1 <= issue ? s1 : '0;
      A_mul_src2 <= issue ? s2 : '0;
      acc        <= acc_nxt;
      if (st == S_IDLE && |req_ready) begin
        a      <= req_src1[32*int'(gidx) +: 32];
        b      <= req_src2[32*int'(gidx) +: 32];
        hi     <= req_hi[gidx];
        rsp_id <= IDW'(gidx);
        st     <= S_ISSUE;
      end
      if (st == S_ISSUE) begin
        pc <= last ? 2'd0 : pc + 2'd1;
        if (last) st <= S_DRAIN;
      end
      if (st == S_DRAIN && drained) begin
        rsp_data  <= hi ? acc_nxt[63:32] : A_mul_cell_result;
        rsp_valid <= 1'b1;
        st        <= S_RESP;
      end
      if (st == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        acc       <= '0;
        st        <= S_IDLE;
      end
    end
endmodule

// File: tb/tb_cpu_0_mult_sched.sv
// tb_cpu_0_mult_sched: randomized bench with a 64-bit product reference and rr grant model
module tb_cpu_0_mult_sched;
  localparam int NREQ = 2;
  localparam int L    = 1;
  localparam int IDW  = 3;
  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid, req_ready, req_hi;
  logic [32*NREQ-1:0]   req_src1, req_src2;
  logic                 rsp_valid, rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_data, A_mul_src1, A_mul_src2, A_mul_cell_result;
  logic [31:0]          cell_q [L];
  logic [31:0]          ma [NREQ];
  logic [31:0]          mb [NREQ];
  logic                 mh [NREQ];
  int                   rr = 0;
  int                   n_chk = 0;
  int                   n_err = 0;

  cpu_0_mult_sched #(.NREQ(NREQ), .CELL_LATENCY(L), .IDW(IDW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_hi(req_hi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .A_mul_src1(A_mul_src1), .A_mul_src2(A_mul_src2), .A_mul_cell_result(A_mul_cell_result)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < L; i++) cell_q[i] <= '0;
    else begin
      cell_q[0] <= A_mul_src1 * A_mul_src2;
      for (int i = 1; i < L; i++) cell_q[i] <= cell_q[i-1];
    end
  assign A_mul_cell_result = cell_q[L-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y, input logic h);
    ma[i] = x;
    mb[i] = y;
    mh[i] = h;
    req_src1[32*i +: 32] = x;
    req_src2[32*i +: 32] = y;
    req_hi[i] = h;
  endtask

  function automatic logic [31:0] rnd32();
    int s = $urandom_range(0, 5);
    return s == 0 ? 32'h0 : s == 1 ? 32'hFFFF_FFFF : s == 2 ? 32'h0001_0000 : $urandom;
  endfunction

  // Entered just after a negedge; returns at the negedge after the response is taken.
  task automatic do_txn(input logic [NREQ-1:0] vm, input bit hold, input int d);
    int w, k, n;
    logic [63:0] p, exp;
    req_valid = vm;
    rsp_ready = (d == 0);
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    w = 0;
    for (int i = NREQ - 1; i >= 0; i--) if (vm[(rr + i) % NREQ]) w = (rr + i) % NREQ;
    chk("grant", 64'(req_ready), 64'(1) << w);
    rr = (w + 1) % NREQ;
    p = {32'h0, ma[w]} * {32'h0, mb[w]};
    exp = mh[w] ? {32'h0, p[63:32]} : {32'h0, p[31:0]};
    @(posedge clk);
    #1;
    if (!hold) req_valid = '0;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 30) begin
      chk("busy_rdy", 64'(req_ready), 64'h0);
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(k), mh[w] ? 64'(5 + L) : 64'(2 + L));
    chk("data", 64'(rsp_data), exp);
    chk("id", 64'(rsp_id), 64'(w));
    chk("resp_rdy", 64'(req_ready), 64'h0);
    repeat (d) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_v", 64'(rsp_valid), 64'h1);
      chk("stall_d", 64'(rsp_data), exp);
      chk("stall_id", 64'(rsp_id), 64'(w));
      chk("stall_rdy", 64'(req_ready), 64'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_done", 64'(rsp_valid), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    req_src1  = '0;
    req_src2  = '0;
    req_hi    = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(req_ready), 64'h0);
    chk("rst_v", 64'(rsp_valid), 64'h0);
    chk("rst_d", 64'(rsp_data), 64'h0);
    chk("rst_id", 64'(rsp_id), 64'h0);
    chk("rst_s1", 64'(A_mul_src1), 64'h0);
    chk("rst_s2", 64'(A_mul_src2), 64'h0);
    req_valid = '0;
    reset_n = 1'b1;
    @(negedge clk);

    set_op(0, 32'd3, 32'd5, 1'b0);
    do_txn(2'b01, 1'b0, 0);
    set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    do_txn(2'b10, 1'b0, 0);
    set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_txn(2'b10, 1'b0, 0);
    set_op(0, 32'h0001_0000, 32'h0001_0000, 1'b1);
    do_txn(2'b01, 1'b0, 0);
    set_op(0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    do_txn(2'b01, 1'b0, 0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, rnd32(), rnd32(), 1'($urandom_range(0, 1)));
      do_txn(2'b11, 1'b1, 0);
    end
    req_valid = '0;

    set_op(0, rnd32(), rnd32(), 1'b1);
    do_txn(2'b01, 1'b0, 10);

    set_op(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    req_valid = 2'b10;
    #1;
    chk("p2_gnt", 64'(req_ready), 64'h2);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("p2_s1", 64'(A_mul_src1), 64'h5678);
    chk("p2_s2", 64'(A_mul_src2), 64'h9ABC);
    reset_n = 1'b0;
    #1;
    chk("mid_s1", 64'(A_mul_src1), 64'h0);
    chk("mid_s2", 64'(A_mul_src2), 64'h0);
    chk("mid_v", 64'(rsp_valid), 64'h0);
    chk("mid_d", 64'(rsp_data), 64'h0);
    chk("mid_id", 64'(rsp_id), 64'h0);
    chk("mid_rdy", 64'(req_ready), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rr = 0;
    @(negedge clk);
    set_op(0, 32'd7, 32'd6, 1'b0);
    do_txn(2'b01, 1'b0, 0);
    chk("post_rst", 64'(rsp_data), 64'h2A);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NREQ; i++) set_op(i, rnd32(), rnd32(), 1'($urandom_range(0, 1)));
      do_txn(NREQ'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    req_valid = '0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
